// File: rtl/rs_pkg.sv
// -----------------------------------------------------------------------------
// rs_pkg
// Shared definitions for the multi-issue reservation station.
//   - default widths / sizes used as parameter defaults by rs_multi_issue
//   - rs_status_t: per-entry status flags (valid + operand-ready bits); the
//     width-dependent payload half of an entry is declared in the top module
//     because its field widths follow the module parameters
//   - lsb_index(): index of the lowest set bit, -1 when the vector is zero
//   - bus_lo(): low bit of slice k in a packed bus of w-bit lanes
// -----------------------------------------------------------------------------
package rs_pkg;

    localparam int RS_DEPTH     = 8;
    localparam int RS_TAG_W     = 5;
    localparam int RS_DATA_W    = 32;
    localparam int RS_CTRL_W    = 9;
    localparam int RS_NUM_CDB   = 4;
    localparam int RS_NUM_ISSUE = 2;

    // Widest vector lsb_index() can scan; callers zero-extend with a size cast.
    localparam int LSB_W = 64;

    typedef struct packed {
        logic valid;
        logic rdy1;
        logic rdy2;
    } rs_status_t;

    function automatic int lsb_index(input logic [LSB_W-1:0] vec);
        int idx;
        idx = -1;
        for (int i = LSB_W - 1; i >= 0; i--) begin
            if (vec[i]) idx = i;
        end
        return idx;
    endfunction

    function automatic int bus_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/rs_age_select.sv
// -----------------------------------------------------------------------------
// rs_age_select
// Age matrix plus a NUM_ISSUE-deep oldest-ready picker.
// older[i][j] = 1 means entry j was inserted before entry i.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   ins_en, ins_idx   an entry is being written this edge, and where
//   valid             entry valid vector (state at cycle start)
//   ready             entries eligible for issue this cycle
//   port_avail        per-port availability
//   grant             one-hot entry grant per port (all-zero = nothing)
// -----------------------------------------------------------------------------
module rs_age_select
    import rs_pkg::*;
#(
    parameter int DEPTH     = RS_DEPTH,
    parameter int NUM_ISSUE = RS_NUM_ISSUE,
    localparam int IDX_W    = $clog2(DEPTH)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              ins_en,
    input  logic [IDX_W-1:0]                  ins_idx,
    input  logic [DEPTH-1:0]                  valid,
    input  logic [DEPTH-1:0]                  ready,
    input  logic [NUM_ISSUE-1:0]              port_avail,
    output logic [NUM_ISSUE-1:0][DEPTH-1:0]   grant
);

    logic [DEPTH-1:0] older [DEPTH];

    // A new entry is younger than every valid entry (its row) and older than
    // none (its column is cleared so stale bits from the slot's previous
    // occupant cannot make it look older than anybody).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) older[i] <= '0;
        end else if (ins_en) begin
            for (int i = 0; i < DEPTH; i++) older[i][ins_idx] <= 1'b0;
            older[ins_idx] <= valid;
        end
    end

    logic [DEPTH-1:0] remaining;
    logic [DEPTH-1:0] oldest;
    int               pick;

    // Each port in ascending order takes the oldest of the still-unclaimed
    // ready entries; an unavailable port takes nothing and claims nothing.
    // NOTE: every variable driven here gets a default before any branch so no
    // path leaves one unassigned and a latch is never inferred.
    always_comb begin
        remaining = ready;
        oldest    = '0;
        pick      = -1;
        for (int p = 0; p < NUM_ISSUE; p++) begin
            grant[p] = '0;
            for (int i = 0; i < DEPTH; i++) begin
                oldest[i] = remaining[i] & ~|(older[i] & remaining);
            end
            pick = lsb_index(LSB_W'(oldest));
            if (port_avail[p] && pick >= 0) begin
                grant[p][pick]  = 1'b1;
                remaining[pick] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rs_multi_issue.sv
// -----------------------------------------------------------------------------
// rs_multi_issue
// Reservation station: DEPTH renamed entries, NUM_CDB result-bus snoop for
// operand wakeup (including the insert cycle), age-ordered selection of up to
// NUM_ISSUE ready entries per cycle into valid/ready issue registers.
// Optional build macro:
//   RS_WAKEUP_BYPASS_EN  selection also sees operands arriving on the CDB this
//                        cycle, with the CDB data routed straight to iss_op*.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   flush                         synchronous squash of entries and issue regs
//   in_valid / in_ready           insert handshake (in_ready = count < DEPTH)
//   in_src{1,2}_{rdy,tag,val}     source operand state at rename
//   in_dest, in_ctrl              destination tag and control word
//   cdb_valid/tag/data            packed result buses, lane k at [k*W +: W]
//   iss_valid / iss_ready         per-port issue handshake
//   iss_dest/op1/op2/ctrl         packed per-port issue payload
//   occupancy                     number of valid entries
// -----------------------------------------------------------------------------
module rs_multi_issue
    import rs_pkg::*;
#(
    parameter int DEPTH     = RS_DEPTH,
    parameter int TAG_W     = RS_TAG_W,
    parameter int DATA_W    = RS_DATA_W,
    parameter int CTRL_W    = RS_CTRL_W,
    parameter int NUM_CDB   = RS_NUM_CDB,
    parameter int NUM_ISSUE = RS_NUM_ISSUE,
    localparam int IDX_W    = $clog2(DEPTH),
    localparam int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_src1_rdy,
    input  logic                          in_src2_rdy,
    input  logic [TAG_W-1:0]              in_src1_tag,
    input  logic [TAG_W-1:0]              in_src2_tag,
    input  logic [DATA_W-1:0]             in_src1_val,
    input  logic [DATA_W-1:0]             in_src2_val,
    input  logic [TAG_W-1:0]              in_dest,
    input  logic [CTRL_W-1:0]             in_ctrl,
    input  logic [NUM_CDB-1:0]            cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]      cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0]     cdb_data,
    output logic [NUM_ISSUE-1:0]          iss_valid,
    input  logic [NUM_ISSUE-1:0]          iss_ready,
    output logic [NUM_ISSUE*TAG_W-1:0]    iss_dest,
    output logic [NUM_ISSUE*DATA_W-1:0]   iss_op1,
    output logic [NUM_ISSUE*DATA_W-1:0]   iss_op2,
    output logic [NUM_ISSUE*CTRL_W-1:0]   iss_ctrl,
    output logic [CNT_W-1:0]              occupancy
);

    typedef struct packed {
        logic [TAG_W-1:0]  tag1;
        logic [TAG_W-1:0]  tag2;
        logic [DATA_W-1:0] val1;
        logic [DATA_W-1:0] val2;
        logic [TAG_W-1:0]  dest;
        logic [CTRL_W-1:0] ctrl;
    } payload_t;

    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    rs_status_t st [DEPTH];
    payload_t   pl [DEPTH];

    // Returns {hit, data}: lowest-index valid CDB whose tag matches.
    function automatic logic [DATA_W:0] snoop(input logic [TAG_W-1:0] tag);
        logic [NUM_CDB-1:0] hit;
        int                 k;
        for (int b = 0; b < NUM_CDB; b++) begin
            hit[b] = cdb_valid[b] && (cdb_tag[bus_lo(b, TAG_W) +: TAG_W] == tag);
        end
        k = lsb_index(LSB_W'(hit));
        if (k < 0) return '0;
        return {1'b1, cdb_data[bus_lo(k, DATA_W) +: DATA_W]};
    endfunction

    // ---------------------------------------------------------------- wakeup
    logic [DEPTH-1:0]  valid_vec, wake1, wake2, sel_rdy;
    logic [DATA_W-1:0] w1_data [DEPTH];
    logic [DATA_W-1:0] w2_data [DEPTH];
    logic [DATA_W-1:0] op1_eff [DEPTH];
    logic [DATA_W-1:0] op2_eff [DEPTH];
    logic              ins1_hit, ins2_hit;
    logic [DATA_W-1:0] ins1_data, ins2_data;
    logic [DATA_W:0]   s;

    always_comb begin
        s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_vec[i] = st[i].valid;
            s            = snoop(pl[i].tag1);
            wake1[i]     = st[i].valid & ~st[i].rdy1 & s[DATA_W];
            w1_data[i]   = s[DATA_W-1:0];
            s            = snoop(pl[i].tag2);
            wake2[i]     = st[i].valid & ~st[i].rdy2 & s[DATA_W];
            w2_data[i]   = s[DATA_W-1:0];
`ifdef RS_WAKEUP_BYPASS_EN
            sel_rdy[i] = st[i].valid & (st[i].rdy1 | wake1[i]) & (st[i].rdy2 | wake2[i]);
            op1_eff[i] = st[i].rdy1 ? pl[i].val1 : w1_data[i];
            op2_eff[i] = st[i].rdy2 ? pl[i].val2 : w2_data[i];
`else
            sel_rdy[i] = st[i].valid & st[i].rdy1 & st[i].rdy2;
            op1_eff[i] = pl[i].val1;
            op2_eff[i] = pl[i].val2;
`endif
        end
        s         = snoop(in_src1_tag);
        ins1_hit  = s[DATA_W];
        ins1_data = s[DATA_W-1:0];
        s         = snoop(in_src2_tag);
        ins2_hit  = s[DATA_W];
        ins2_data = s[DATA_W-1:0];
    end

    // ---------------------------------------------------------------- insert
    logic             accept;
    logic [IDX_W-1:0] ins_idx;
    logic [DEPTH-1:0] ins_onehot;

    assign in_ready   = (occupancy != FULL);
    assign accept     = in_valid & in_ready & ~flush;
    // Free slots judged on start-of-cycle valid bits: a slot issuing this
    // cycle still reads as occupied, so it is reused one cycle later.
    assign ins_idx    = IDX_W'(lsb_index(LSB_W'(~valid_vec)));
    assign ins_onehot = accept ? (DEPTH'(1) << ins_idx) : '0;

    // ---------------------------------------------------------------- select
    logic [NUM_ISSUE-1:0]            port_avail;
    logic [NUM_ISSUE-1:0][DEPTH-1:0] grant;

    assign port_avail = ~iss_valid | iss_ready;

    rs_age_select #(
        .DEPTH     (DEPTH),
        .NUM_ISSUE (NUM_ISSUE)
    ) u_age_select (
        .clk        (clk),
        .rst        (rst),
        .ins_en     (accept),
        .ins_idx    (ins_idx),
        .valid      (valid_vec),
        .ready      (sel_rdy),
        .port_avail (port_avail),
        .grant      (grant)
    );

    logic [DEPTH-1:0]  issued;
    logic [CNT_W-1:0]  n_iss;
    logic [TAG_W-1:0]  nxt_dest [NUM_ISSUE];
    logic [DATA_W-1:0] nxt_op1  [NUM_ISSUE];
    logic [DATA_W-1:0] nxt_op2  [NUM_ISSUE];
    logic [CTRL_W-1:0] nxt_ctrl [NUM_ISSUE];
    int                g;

    // Unassigned ports get an all-zero payload, which is what an available
    // idle port must show.
    always_comb begin
        issued = '0;
        n_iss  = '0;
        g      = -1;
        for (int p = 0; p < NUM_ISSUE; p++) begin
            nxt_dest[p] = '0;
            nxt_op1[p]  = '0;
            nxt_op2[p]  = '0;
            nxt_ctrl[p] = '0;
            issued      = issued | grant[p];
            g           = lsb_index(LSB_W'(grant[p]));
            if (g >= 0) begin
                n_iss       = n_iss + ONE;
                nxt_dest[p] = pl[g].dest;
                nxt_op1[p]  = op1_eff[g];
                nxt_op2[p]  = op2_eff[g];
                nxt_ctrl[p] = pl[g].ctrl;
            end
        end
    end

    // ---------------------------------------------------------------- state
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) st[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) st[i].valid <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (issued[i]) begin
                    st[i].valid <= 1'b0;
                end else if (ins_onehot[i]) begin
                    st[i] <= '{valid: 1'b1,
                               rdy1:  in_src1_rdy | ins1_hit,
                               rdy2:  in_src2_rdy | ins2_hit};
                end else begin
                    if (wake1[i]) st[i].rdy1 <= 1'b1;
                    if (wake2[i]) st[i].rdy2 <= 1'b1;
                end
            end
        end
    end

    // NOTE: the payload array has no reset; nothing reads it while the
    // matching valid bit is clear, so resetting it would only cost area.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (ins_onehot[i]) begin
                pl[i] <= '{tag1: in_src1_tag,
                           tag2: in_src2_tag,
                           val1: in_src1_rdy ? in_src1_val : ins1_data,
                           val2: in_src2_rdy ? in_src2_val : ins2_data,
                           dest: in_dest,
                           ctrl: in_ctrl};
            end else begin
                if (wake1[i]) pl[i].val1 <= w1_data[i];
                if (wake2[i]) pl[i].val2 <= w2_data[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occupancy <= '0;
        end else if (flush) begin
            occupancy <= '0;
        end else begin
            occupancy <= occupancy + (accept ? ONE : '0) - n_iss;
        end
    end

    // Issue registers: available ports load (or clear), stalled ports hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iss_valid <= '0;
            iss_dest  <= '0;
            iss_op1   <= '0;
            iss_op2   <= '0;
            iss_ctrl  <= '0;
        end else if (flush) begin
            iss_valid <= '0;
            iss_dest  <= '0;
            iss_op1   <= '0;
            iss_op2   <= '0;
            iss_ctrl  <= '0;
        end else begin
            for (int p = 0; p < NUM_ISSUE; p++) begin
                if (port_avail[p]) begin
                    iss_valid[p]                         <= |grant[p];
                    iss_dest[bus_lo(p, TAG_W) +: TAG_W]  <= nxt_dest[p];
                    iss_op1[bus_lo(p, DATA_W) +: DATA_W] <= nxt_op1[p];
                    iss_op2[bus_lo(p, DATA_W) +: DATA_W] <= nxt_op2[p];
                    iss_ctrl[bus_lo(p, CTRL_W) +: CTRL_W] <= nxt_ctrl[p];
                end
            end
        end
    end

endmodule

// File: tb/tb_rs_multi_issue.sv
// -----------------------------------------------------------------------------
// tb_rs_multi_issue
// Directed bench for rs_multi_issue at default parameters (DEPTH=8, TAG_W=5,
// DATA_W=32, CTRL_W=9, NUM_CDB=4, NUM_ISSUE=2). Inputs change 1 time unit
// after the rising edge; outputs are compared at that same point, well away
// from the next edge.
// -----------------------------------------------------------------------------
module tb_rs_multi_issue;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic         in_src1_rdy, in_src2_rdy;
    logic [4:0]   in_src1_tag, in_src2_tag;
    logic [31:0]  in_src1_val, in_src2_val;
    logic [4:0]   in_dest;
    logic [8:0]   in_ctrl;
    logic [3:0]   cdb_valid;
    logic [19:0]  cdb_tag;
    logic [127:0] cdb_data;
    logic [1:0]   iss_valid;
    logic [1:0]   iss_ready;
    logic [9:0]   iss_dest;
    logic [63:0]  iss_op1, iss_op2;
    logic [17:0]  iss_ctrl;
    logic [3:0]   occupancy;

    int checks   = 0;
    int failures = 0;

    rs_multi_issue dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_src1_rdy (in_src1_rdy),
        .in_src2_rdy (in_src2_rdy),
        .in_src1_tag (in_src1_tag),
        .in_src2_tag (in_src2_tag),
        .in_src1_val (in_src1_val),
        .in_src2_val (in_src2_val),
        .in_dest     (in_dest),
        .in_ctrl     (in_ctrl),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_data    (cdb_data),
        .iss_valid   (iss_valid),
        .iss_ready   (iss_ready),
        .iss_dest    (iss_dest),
        .iss_op1     (iss_op1),
        .iss_op2     (iss_op2),
        .iss_ctrl    (iss_ctrl),
        .occupancy   (occupancy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [4:0]  p_dest(input int p); return iss_dest[p*5 +: 5];   endfunction
    function automatic logic [31:0] p_op1 (input int p); return iss_op1[p*32 +: 32];  endfunction
    function automatic logic [31:0] p_op2 (input int p); return iss_op2[p*32 +: 32];  endfunction
    function automatic logic [8:0]  p_ctrl(input int p); return iss_ctrl[p*9 +: 9];   endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ins(input logic [4:0] dest,
                             input logic r1, input logic [4:0] t1, input logic [31:0] v1,
                             input logic r2, input logic [4:0] t2, input logic [31:0] v2,
                             input logic [8:0] ctrl);
        in_valid    = 1'b1;
        in_dest     = dest;
        in_src1_rdy = r1; in_src1_tag = t1; in_src1_val = v1;
        in_src2_rdy = r2; in_src2_tag = t2; in_src2_val = v2;
        in_ctrl     = ctrl;
    endtask

    task automatic set_cdb(input int k, input logic [4:0] tag, input logic [31:0] data);
        cdb_valid[k]          = 1'b1;
        cdb_tag[k*5 +: 5]     = tag;
        cdb_data[k*32 +: 32]  = data;
    endtask

    task automatic clear_cdb();
        cdb_valid = '0;
        cdb_tag   = '0;
        cdb_data  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_src1_rdy = 0; in_src2_rdy = 0; in_src1_tag = 0; in_src2_tag = 0;
        in_src1_val = 0; in_src2_val = 0; in_dest = 0; in_ctrl = 0;
        iss_ready = 2'b11;
        clear_cdb();
        #23;
        checks++; if (iss_valid !== 2'b00) begin failures++; $display("FAIL reset_iss_valid: got %b expected 00", iss_valid); end
        checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (iss_dest !== 10'd0 || iss_op1 !== 64'd0) begin failures++; $display("FAIL reset_payload: got dest=%h op1=%h expected 0", iss_dest, iss_op1); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        drive_ins(5'd3, 1, 5'd0, 32'h11, 1, 5'd0, 32'h22, 9'h1A5);
        tick();
        in_valid = 1'b0;
        checks++; if (occupancy !== 4'd1) begin failures++; $display("FAIL basic_occ_after_insert: got %0d expected 1", occupancy); end
        checks++; if (iss_valid !== 2'b00) begin failures++; $display("FAIL basic_no_early_issue: got %b expected 00", iss_valid); end
        tick();
        checks++; if (iss_valid !== 2'b01) begin failures++; $display("FAIL basic_iss_valid: got %b expected 01", iss_valid); end
        checks++; if (p_dest(0) !== 5'd3) begin failures++; $display("FAIL basic_dest: got %0d expected 3", p_dest(0)); end
        checks++; if (p_op1(0) !== 32'h11 || p_op2(0) !== 32'h22) begin failures++; $display("FAIL basic_ops: got %h/%h expected 11/22", p_op1(0), p_op2(0)); end
        checks++; if (p_ctrl(0) !== 9'h1A5) begin failures++; $display("FAIL basic_ctrl: got %h expected 1a5", p_ctrl(0)); end
        checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL basic_occ_after_issue: got %0d expected 0", occupancy); end
        tick();
        checks++; if (iss_valid !== 2'b00 || p_dest(0) !== 5'd0) begin failures++; $display("FAIL basic_idle_clear: got valid=%b dest=%0d expected 00/0", iss_valid, p_dest(0)); end
    endtask

    task automatic test_wakeup();
        drive_ins(5'd10, 0, 5'd5, 32'h0, 1, 5'd0, 32'h2, 9'h001);
        tick();
        drive_ins(5'd11, 0, 5'd5, 32'h0, 1, 5'd5, 32'h3, 9'h002);
        tick();
        in_valid = 1'b0;
        checks++; if (occupancy !== 4'd2 || iss_valid !== 2'b00) begin failures++; $display("FAIL wake_waiting: got occ=%0d valid=%b expected 2/00", occupancy, iss_valid); end
        set_cdb(0, 5'd5, 32'hAB);
        set_cdb(1, 5'd5, 32'hCD);
        tick();
        clear_cdb();
        checks++; if (iss_valid !== 2'b00) begin failures++; $display("FAIL wake_no_bypass: got %b expected 00", iss_valid); end
        tick();
        checks++; if (iss_valid !== 2'b11) begin failures++; $display("FAIL wake_dual_issue: got %b expected 11", iss_valid); end
        checks++; if (p_dest(0) !== 5'd10 || p_dest(1) !== 5'd11) begin failures++; $display("FAIL wake_order: got %0d/%0d expected 10/11", p_dest(0), p_dest(1)); end
        checks++; if (p_op1(0) !== 32'hAB || p_op1(1) !== 32'hAB) begin failures++; $display("FAIL wake_data: got %h/%h expected ab/ab", p_op1(0), p_op1(1)); end
        checks++; if (p_op2(1) !== 32'h3) begin failures++; $display("FAIL wake_ready_kept: got %h expected 3", p_op2(1)); end
        checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL wake_occ: got %0d expected 0", occupancy); end
        tick();
    endtask

    task automatic test_full_and_age();
        for (int i = 0; i < 8; i++) begin
            drive_ins(5'(i), 0, 5'd20, 32'h0, 1, 5'd0, 32'(i), 9'h0);
            tick();
        end
        checks++; if (occupancy !== 4'd8 || in_ready !== 1'b0) begin failures++; $display("FAIL full_state: got occ=%0d in_ready=%b expected 8/0", occupancy, in_ready); end
        drive_ins(5'd31, 1, 5'd0, 32'h1, 1, 5'd0, 32'h1, 9'h0);
        tick();
        in_valid = 1'b0;
        checks++; if (occupancy !== 4'd8 || iss_valid !== 2'b00) begin failures++; $display("FAIL full_drop: got occ=%0d valid=%b expected 8/00", occupancy, iss_valid); end
        set_cdb(0, 5'd20, 32'h77);
        tick();
        clear_cdb();
        tick();
        checks++; if (iss_valid !== 2'b11 || p_dest(0) !== 5'd0 || p_dest(1) !== 5'd1) begin failures++; $display("FAIL full_drain0: got valid=%b %0d/%0d expected 11 0/1", iss_valid, p_dest(0), p_dest(1)); end
        checks++; if (p_op1(0) !== 32'h77 || occupancy !== 4'd6) begin failures++; $display("FAIL full_drain0_data: got op1=%h occ=%0d expected 77/6", p_op1(0), occupancy); end
        drive_ins(5'd30, 1, 5'd0, 32'h30, 1, 5'd0, 32'h31, 9'h0);
        tick();
        in_valid = 1'b0;
        checks++; if (p_dest(0) !== 5'd2 || p_dest(1) !== 5'd3 || occupancy !== 4'd5) begin failures++; $display("FAIL full_drain1: got %0d/%0d occ=%0d expected 2/3 occ=5", p_dest(0), p_dest(1), occupancy); end
        tick();
        checks++; if (p_dest(0) !== 5'd4 || p_dest(1) !== 5'd5) begin failures++; $display("FAIL age_older_first: got %0d/%0d expected 4/5", p_dest(0), p_dest(1)); end
        tick();
        checks++; if (p_dest(0) !== 5'd6 || p_dest(1) !== 5'd7 || occupancy !== 4'd1) begin failures++; $display("FAIL full_drain3: got %0d/%0d occ=%0d expected 6/7 occ=1", p_dest(0), p_dest(1), occupancy); end
        tick();
        checks++; if (iss_valid !== 2'b01 || p_dest(0) !== 5'd30 || p_op2(0) !== 32'h31) begin failures++; $display("FAIL age_young_last: got valid=%b dest=%0d op2=%h expected 01/30/31", iss_valid, p_dest(0), p_op2(0)); end
        checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL full_empty: got %0d expected 0", occupancy); end
        tick();
    endtask

    task automatic test_stall();
        for (int i = 1; i <= 5; i++) begin
            drive_ins(5'(i), 0, 5'd9, 32'h0, 1, 5'd0, 32'(i * 16), 9'h0);
            tick();
        end
        in_valid = 1'b0;
        set_cdb(0, 5'd9, 32'h99);
        tick();
        clear_cdb();
        iss_ready = 2'b10;
        tick();
        checks++; if (iss_valid !== 2'b11 || p_dest(0) !== 5'd1 || p_dest(1) !== 5'd2) begin failures++; $display("FAIL stall_first: got valid=%b %0d/%0d expected 11 1/2", iss_valid, p_dest(0), p_dest(1)); end
        tick();
        checks++; if (p_dest(0) !== 5'd1 || p_op2(0) !== 32'h10 || p_op1(0) !== 32'h99) begin failures++; $display("FAIL stall_hold: got dest=%0d op1=%h op2=%h expected 1/99/10", p_dest(0), p_op1(0), p_op2(0)); end
        checks++; if (iss_valid !== 2'b11 || p_dest(1) !== 5'd3) begin failures++; $display("FAIL stall_port1_a: got valid=%b dest=%0d expected 11/3", iss_valid, p_dest(1)); end
        tick();
        checks++; if (p_dest(0) !== 5'd1 || p_dest(1) !== 5'd4) begin failures++; $display("FAIL stall_port1_b: got %0d/%0d expected 1/4", p_dest(0), p_dest(1)); end
        iss_ready = 2'b11;
        tick();
        checks++; if (iss_valid !== 2'b01 || p_dest(0) !== 5'd5) begin failures++; $display("FAIL stall_release: got valid=%b dest=%0d expected 01/5", iss_valid, p_dest(0)); end
        checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL stall_occ: got %0d expected 0", occupancy); end
        tick();
    endtask

    task automatic test_insert_snoop();
        drive_ins(5'd12, 1, 5'd0, 32'h1, 0, 5'd7, 32'h0, 9'h0C3);
        set_cdb(2, 5'd7, 32'h5);
        set_cdb(3, 5'd7, 32'h9);
        tick();
        in_valid = 1'b0;
        clear_cdb();
        checks++; if (occupancy !== 4'd1 || iss_valid !== 2'b00) begin failures++; $display("FAIL snoop_insert: got occ=%0d valid=%b expected 1/00", occupancy, iss_valid); end
        tick();
        checks++; if (iss_valid !== 2'b01 || p_dest(0) !== 5'd12) begin failures++; $display("FAIL snoop_issue: got valid=%b dest=%0d expected 01/12", iss_valid, p_dest(0)); end
        checks++; if (p_op2(0) !== 32'h5 || p_op1(0) !== 32'h1) begin failures++; $display("FAIL snoop_data: got op1=%h op2=%h expected 1/5", p_op1(0), p_op2(0)); end
        tick();
    endtask

    task automatic test_flush();
        iss_ready = 2'b00;
        for (int i = 0; i < 6; i++) begin
            drive_ins(5'(20 + i), 1, 5'd0, 32'(i), 1, 5'd0, 32'(i), 9'h0);
            tick();
        end
        in_valid = 1'b0;
        checks++; if (occupancy !== 4'd4 || iss_valid !== 2'b11) begin failures++; $display("FAIL flush_setup: got occ=%0d valid=%b expected 4/11", occupancy, iss_valid); end
        flush = 1'b1;
        drive_ins(5'd26, 1, 5'd0, 32'h1, 1, 5'd0, 32'h1, 9'h0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        iss_ready = 2'b11;
        checks++; if (occupancy !== 4'd0 || iss_valid !== 2'b00 || in_ready !== 1'b1) begin failures++; $display("FAIL flush_clear: got occ=%0d valid=%b in_ready=%b expected 0/00/1", occupancy, iss_valid, in_ready); end
        tick();
        tick();
        checks++; if (occupancy !== 4'd0 || iss_valid !== 2'b00) begin failures++; $display("FAIL flush_insert_dropped: got occ=%0d valid=%b expected 0/00", occupancy, iss_valid); end
        drive_ins(5'd27, 1, 5'd0, 32'h44, 1, 5'd0, 32'h55, 9'h0);
        tick();
        in_valid = 1'b0;
        tick();
        checks++; if (iss_valid !== 2'b01 || p_dest(0) !== 5'd27 || p_op1(0) !== 32'h44) begin failures++; $display("FAIL flush_recover: got valid=%b dest=%0d op1=%h expected 01/27/44", iss_valid, p_dest(0), p_op1(0)); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wakeup();
        test_full_and_age();
        test_stall();
        test_insert_snoop();
        test_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rs_multi_issue.md
Name: rs_multi_issue

Overview:
- Parameterised reservation station for the out-of-order core.
- Holds DEPTH renamed instructions and snoops NUM_CDB result buses (ALU and load) for operand wakeup.
- Issues up to NUM_ISSUE ready instructions per cycle, oldest first, to execution units through a valid/ready handshake.
- Sits between rename/ROB allocation and the functional units. Adds flush, back-pressure, insert-cycle snoop and age ordering.

Parameters:
- DEPTH, 8: number of entries; power of 2, ≥ 2.
- TAG_W, 5: ROB/physical tag width.
- DATA_W, 32: operand width.
- CTRL_W, 9: decoded control word width.
- NUM_CDB, 4: number of broadcast buses.
- NUM_ISSUE, 2: number of issue ports, ≤ DEPTH.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash of all entries and issue registers.
- in_valid  in  1  insert request.
- in_ready  out  1  at least one free entry (registered count).
- in_src1_rdy, in_src2_rdy  in  1 each  operand value already valid.
- in_src1_tag, in_src2_tag  in  TAG_W each  producer tag when the operand is not ready.
- in_src1_val, in_src2_val  in  DATA_W each  operand value when ready.
- in_dest  in  TAG_W  destination tag.
- in_ctrl  in  CTRL_W  control word.
- cdb_valid  in  NUM_CDB  per-bus valid.
- cdb_tag  in  NUM_CDB*TAG_W  packed tags; bus k occupies bits [k*TAG_W +: TAG_W].
- cdb_data  in  NUM_CDB*DATA_W  packed results.
- iss_valid  out  NUM_ISSUE  issue register valid.
- iss_ready  in  NUM_ISSUE  functional unit accepts.
- iss_dest  out  NUM_ISSUE*TAG_W  packed destination tags.
- iss_op1, iss_op2  out  NUM_ISSUE*DATA_W each  packed operands.
- iss_ctrl  out  NUM_ISSUE*CTRL_W  packed control words.
- occupancy  out  $clog2(DEPTH)+1  valid entry count.

Behaviour:
- Reset (rst low, asynchronous): every entry invalid; age matrix cleared; iss_valid=0; iss_dest/op1/op2/ctrl=0; occupancy=0; in_ready=1.
- Entry state: valid, rdy1, rdy2, tag1, tag2, val1, val2, dest, ctrl, and age-matrix row.
- Insert:
  - Accepted at an edge when in_valid & in_ready & ~flush.
  - Written to the lowest-index free entry, where "free" is judged at the start of the cycle. A slot freed by issue in the same cycle is not reused until the next cycle.
  - in_valid while in_ready=0 is ignored; no state change.
- Insert-cycle snoop: an incoming not-ready operand whose tag matches a valid CDB in the same cycle is captured as ready with that CDB's data.
- Wakeup:
  - Each valid entry with rdyN=0 compares tagN against all valid CDBs; on a match, valN ← data and rdyN ← 1.
  - If several CDBs match, the lowest index wins.
  - Ready operands are never overwritten.
- Age:
  - DEPTH×DEPTH age matrix. On insert, the new entry's row is marked older-than none and younger-than all valid entries.
  - Oldest = a ready entry with no older ready entry.
- Select/issue:
  - A port is available when iss_valid[p]=0 or iss_ready[p]=1.
  - Each cycle, the oldest ready entries (rdy1&rdy2, state at cycle start) are assigned in age order to available ports in ascending port index.
  - Assigned entries are freed at the edge. The port register loads dest, op1, op2, ctrl and iss_valid[p]←1.
  - An available port with nothing assigned clears iss_valid[p] and zeroes its payload.
  - A stalled port (iss_valid=1, iss_ready=0) holds its payload stable.
- Latency, no bypass:
  - Operands ready at insert edge E → iss_valid earliest after edge E+1.
  - CDB wakeup sampled at edge E → issue after edge E+1.
- Flush:
  - Priority over insert, wakeup and issue.
  - At the edge, all entries go invalid, iss_valid=0, occupancy=0.
  - Age matrix contents are don't-care once entries are invalid.
- occupancy = previous + inserts − issued; maximum value DEPTH.

Optional Feature:
- RS_WAKEUP_BYPASS_EN defined: select also sees operands arriving on the CDB in the current cycle. A woken entry can issue at the same edge E, with the CDB data routed to iss_op directly.
- Undefined: select uses registered ready bits only. Latency is as specified above.

Decomposition:
- Package rs_pkg holds: default widths; a function for the lowest-set-bit index; the entry struct layout; the packed-bus slice helpers.
- One sub-module, rs_age_select: the age matrix plus NUM_ISSUE-deep oldest-ready picker, returning one-hot grants per port.

Test Plan:
- Reset then insert dest=3, both operands ready (0x11, 0x22) → after 2 edges port0 shows dest=3, op1=0x11, op2=0x22; occupancy returns to 0 after issue.
- Insert entries A(tag1=5, waiting) then B(tag1=5, waiting); CDB0 tag=5 data=0xAB → both wake; A issues on port0 and B on port1 in the same cycle, both op1=0xAB.
- Fill 8 entries with no wakeups → in_ready=0; a 9th insert is dropped; occupancy stays 8.
- Port0 iss_ready=0 while 3 entries are ready → port0 payload held stable; the other entries issue via port1 one per cycle; on release, port0 accepts the next oldest.
- Insert with src2 tag=7 while CDB2 tag=7 data=0x5 in the same cycle → entry ready with op2=0x5 and issues normally.
- Flush asserted with 4 valid entries and iss_valid=2'b11 → next edge: occupancy=0, iss_valid=0; an insert in the flush cycle is discarded.
